// File: rtl/l1_l2_request_arbiter_pkg.sv
// Shared L1->L2 request defines: packet layout, op encodings and requester indices.
// Used by the arbiter built with or without L2_ARB_ROUND_ROBIN_EN.
package l1_l2_request_arbiter_pkg;

  localparam int CORE_W = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam int REQ_ICACHE      = 0;
  localparam int REQ_DCACHE      = 1;
  localparam int REQ_STBUF       = 2;
  localparam int NUM_REQ_DEFAULT = 3;

  typedef enum logic [1:0] {
    L2_OP_IFETCH   = 2'd0,
    L2_OP_LOAD     = 2'd1,
    L2_OP_STORE    = 2'd2,
    L2_OP_PREFETCH = 2'd3
  } l2_op_e;

  typedef struct packed {
    logic              valid;
    logic [CORE_W-1:0] core;
    l2_op_e            op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } l2req_packet_t;

  // A single-requester build still needs a 1-bit pointer.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/l1_l2_request_arbiter_if.sv
// Requester/L2 handshake bundle; slave = arbiter side, master = requesters plus L2.
interface l1_l2_request_arbiter_if #(
  parameter int NUM_REQUESTERS = 3
);
  import l1_l2_request_arbiter_pkg::*;

  logic [NUM_REQUESTERS-1:0]                req_valid;
  l2req_packet_t [NUM_REQUESTERS-1:0]       req_packet;
  logic [NUM_REQUESTERS-1:0]                req_ack;
  logic                                     l2req_ready;
  l2req_packet_t                            l2req_packet;
  logic                                     pc_event_l2_stall;

  modport slave (
    input  req_valid, req_packet, l2req_ready,
    output req_ack, l2req_packet, pc_event_l2_stall
  );

  modport master (
    output req_valid, req_packet, l2req_ready,
    input  req_ack, l2req_packet, pc_event_l2_stall
  );

endinterface

// File: rtl/l1_l2_request_arbiter_arbiter_rr.sv
// One-hot grant selection with a last-grant pointer. L2_ARB_ROUND_ROBIN_EN selects
// round-robin after the pointer; otherwise lowest index wins and the pointer just tracks.
module arbiter_rr
  import l1_l2_request_arbiter_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int PTR_W = ptr_width(N);

  logic [PTR_W-1:0] last_q, last_d;
  logic [PTR_W-1:0] gidx;
  logic             found;

  always_comb begin
    int idx;
    grant = '0;
    gidx  = last_q;
    found = 1'b0;
    idx   = 0;
`ifdef L2_ARB_ROUND_ROBIN_EN
    // Search starts one past the last winner and wraps.
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      idx = i;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PTR_W'(idx);
      end
    end
`endif
  end

  always_comb begin
    last_d = last_q;
    if (update_en && found) last_d = gidx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= PTR_W'(N - 1);
    else       last_q <= last_d;
  end

  a_ptr_range: assert property (@(posedge clk) disable iff (reset) int'(last_q) < N);
  a_grant_oh:  assert property (@(posedge clk) disable iff (reset) $onehot0(grant));

endmodule

// File: rtl/l1_l2_request_arbiter.sv
// Arbitrates L1 miss/store requests into a single registered L2 request slot.
// Grant policy: fixed priority by default, round-robin with L2_ARB_ROUND_ROBIN_EN.
module l1_l2_request_arbiter
  import l1_l2_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = 3,
  parameter int CORE_ID        = 0
) (
  input logic                      clk,
  input logic                      reset,
  l1_l2_request_arbiter_if.slave   bus
);

  logic [NUM_REQUESTERS-1:0] grant;
  logic                      slot_free;
  logic                      any_req;
  logic                      grant_en;
  l2req_packet_t             sel_pkt;
  l2req_packet_t             pkt_q, pkt_d;

  // Slot frees in the same cycle L2 takes the current packet, giving back-to-back issue.
  assign slot_free = !pkt_q.valid || bus.l2req_ready;
  assign any_req   = |bus.req_valid;
  assign grant_en  = slot_free && any_req && !reset;

  arbiter_rr #(
    .N (NUM_REQUESTERS)
  ) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .update_en (grant_en),
    .grant     (grant)
  );

  always_comb begin
    sel_pkt = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      if (grant[i]) sel_pkt = bus.req_packet[i];
    end
  end

  always_comb begin
    pkt_d = pkt_q;
    if (grant_en) begin
      pkt_d       = sel_pkt;
      pkt_d.valid = 1'b1;
      pkt_d.core  = CORE_W'(CORE_ID);
    end else if (pkt_q.valid && bus.l2req_ready) begin
      pkt_d.valid = 1'b0;
    end
  end

  // Reset drops any in-flight packet; requesters retry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pkt_q <= '0;
    else       pkt_q <= pkt_d;
  end

  assign bus.req_ack           = grant & {NUM_REQUESTERS{grant_en}};
  assign bus.l2req_packet      = pkt_q;
  assign bus.pc_event_l2_stall = pkt_q.valid && !bus.l2req_ready && !reset;

  a_hold_stable: assert property (@(posedge clk) disable iff (reset)
    (pkt_q.valid && !bus.l2req_ready) |=> $stable(pkt_q));

endmodule

// File: tb/tb_l1_l2_request_arbiter.sv
// Directed + randomized bench for l1_l2_request_arbiter against a cycle-level reference model.
module tb_l1_l2_request_arbiter;
  import l1_l2_request_arbiter_pkg::*;

  localparam int N       = 3;
  localparam int CORE_ID = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  l1_l2_request_arbiter_if #(.NUM_REQUESTERS(N)) bus();

  l1_l2_request_arbiter #(
    .NUM_REQUESTERS (N),
    .CORE_ID        (CORE_ID)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  l2req_packet_t pk [N];
  l2req_packet_t m_pkt;
  l2req_packet_t held;
  int            m_last;
  int            last_g;
  logic [N-1:0]  exp_ack;
  logic          exp_stall;
  int            exp_seq [4];
  logic [N-1:0]  pend;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic l2req_packet_t mk(input int r);
    l2req_packet_t p;
    p.valid = 1'($urandom_range(0, 1));
    p.core  = 4'($urandom);
    p.op    = (r == REQ_ICACHE) ? L2_OP_IFETCH :
              (r == REQ_DCACHE) ? L2_OP_LOAD :
              ($urandom_range(0, 1) != 0) ? L2_OP_STORE : L2_OP_PREFETCH;
    p.addr  = $urandom;
    p.data  = $urandom;
    return p;
  endfunction

  // Winner from the policy rules alone.
  function automatic int pick(input logic [N-1:0] v);
`ifdef L2_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= N; k++) if (v[(m_last + k) % N]) return (m_last + k) % N;
`else
    for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] v, input logic r);
    @(negedge clk);
    bus.req_valid   = v;
    bus.l2req_ready = r;
    for (int i = 0; i < N; i++) bus.req_packet[i] = pk[i];
    #1;
    exp_ack = '0;
    last_g  = -1;
    if ((!m_pkt.valid || r) && v != '0) begin
      last_g          = pick(v);
      exp_ack[last_g] = 1'b1;
    end
    exp_stall = m_pkt.valid && !r;
    check("req_ack", bus.req_ack, exp_ack);
    check("l2_stall", bus.pc_event_l2_stall, exp_stall);
    checks++;
    assert ($onehot0(bus.req_ack)) else begin
      errors++;
      $error("FAIL ack_onehot0: observed %b expected one-hot or zero", bus.req_ack);
    end
    @(posedge clk);
    if (last_g >= 0) begin
      m_pkt       = pk[last_g];
      m_pkt.valid = 1'b1;
      m_pkt.core  = 4'(CORE_ID);
      m_last      = last_g;
    end else if (m_pkt.valid && r) begin
      m_pkt.valid = 1'b0;
    end
    #1;
    check("l2req_packet", bus.l2req_packet, m_pkt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_pkt", bus.l2req_packet, '0);
    check("rst_ack", bus.req_ack, '0);
    check("rst_stall", bus.pc_event_l2_stall, 1'b0);
    m_pkt  = '0;
    m_last = N - 1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset           = 1'b1;
    bus.req_valid   = '1;
    bus.l2req_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pk[i]             = mk(i);
      bus.req_packet[i] = pk[i];
    end
    m_pkt  = '0;
    m_last = N - 1;
    #1;
    check("rst_pkt0", bus.l2req_packet, '0);
    check("rst_ack0", bus.req_ack, '0);
    check("rst_stall0", bus.pc_event_l2_stall, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // Single dcache request, then drain.
    pk[1] = mk(1);
    cycle(3'b010, 1'b1);
    check("single_grant", last_g, 1);
    check("single_op", bus.l2req_packet.op, L2_OP_LOAD);
    check("single_core", bus.l2req_packet.core, 4'(CORE_ID));
    cycle(3'b000, 1'b1);
    check("drain_valid", bus.l2req_packet.valid, 1'b0);

    // Backpressure for five cycles with another request waiting, then back-to-back.
    pk[0] = mk(0);
    cycle(3'b001, 1'b1);
    held       = pk[0];
    held.valid = 1'b1;
    held.core  = 4'(CORE_ID);
    pk[2]      = mk(2);
    repeat (5) begin
      cycle(3'b100, 1'b0);
      check("bp_held", bus.l2req_packet, held);
      check("bp_stall", bus.pc_event_l2_stall, 1'b1);
    end
    cycle(3'b100, 1'b1);
    check("b2b_grant", last_g, 2);
    check("b2b_valid", bus.l2req_packet.valid, 1'b1);
    cycle(3'b000, 1'b1);

    // All three requesters held with L2 always ready.
    do_reset();
`ifdef L2_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      cycle(3'b111, 1'b1);
      check("hold_seq", last_g, exp_seq[k]);
      check("hold_nobubble", bus.l2req_packet.valid, 1'b1);
      pk[last_g] = mk(last_g);
    end
    cycle(3'b110, 1'b1);
    check("drop0_grant", last_g, 1);
    cycle(3'b100, 1'b1);
    check("drop1_grant", last_g, 2);
    cycle(3'b000, 1'b1);

    // Reset while a packet is stalled; requester 0 must win afterwards.
    cycle(3'b001, 1'b1);
    pk[0] = mk(0);
    cycle(3'b111, 1'b0);
    do_reset();
    cycle(3'b111, 1'b1);
    check("post_rst_grant", last_g, 0);
    pk[0] = mk(0);
    cycle(3'b000, 1'b1);

    // Randomized traffic honouring hold-until-ack.
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          pk[i]   = mk(i);
        end
      end
      cycle(pend, 1'($urandom_range(0, 9) < 7));
      if (last_g >= 0) pend[last_g] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/l1_l2_request_arbiter.md
L1_L2_REQUEST_ARBITER -- requirements
Module: l1_l2_request_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQUESTERS, default 3, meaning the number of L2 request sources (index 0 icache miss queue, 1 dcache miss queue, 2 store buffer).
REQ-002 SHALL have parameter CORE_ID, default 0, meaning the core number stamped into forwarded packets.
REQ-003 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  NUM_REQUESTERS  per-requester request pending.
REQ-006 SHALL have port req_packet  input  NUM_REQUESTERS x l2req_packet_t  per-requester packet; valid field ignored.
REQ-007 SHALL have port req_ack  output  NUM_REQUESTERS  one-hot pulse: packet captured this cycle.
REQ-008 SHALL have port l2req_ready  input  1  L2 accepts the presented packet this cycle.
REQ-009 SHALL have port l2req_packet  output  l2req_packet_t  registered packet to L2; valid field marks occupancy.
REQ-010 SHALL have port pc_event_l2_stall  output  1  output held valid with l2req_ready low this cycle.

Function
REQ-011 SHALL hold one output slot; slot is "free" when l2req_packet.valid is 0 or (l2req_packet.valid and l2req_ready) this cycle.
REQ-012 SHALL, when slot free and any req_valid set, grant exactly one requester, assert its req_ack bit combinationally in the same cycle, and load its packet into l2req_packet with valid=1 and core=CORE_ID at the next edge.
REQ-013 SHALL give latency 1: request in cycle N with free slot -> packet visible at l2req_packet in cycle N+1.
REQ-014 SHALL keep l2req_packet bit-stable while valid and l2req_ready is low.
REQ-015 SHALL allow back-to-back issue: L2 acceptance and capture of a new grant in the same cycle yields a new packet next cycle with no bubble.
REQ-016 SHALL clear l2req_packet.valid at the next edge when L2 accepts and no request is pending.
REQ-017 SHALL assert no req_ack bit when slot not free; requesters hold req_valid and req_packet until acked.
REQ-018 SHALL keep a last-grant pointer (width clog2(NUM_REQUESTERS)), updated only on a grant.
REQ-019 SHALL never let req_ack be non-one-hot; bench asserts $onehot0(req_ack).
REQ-020 SHALL assert pc_event_l2_stall exactly when l2req_packet.valid and !l2req_ready.

Reset
REQ-021 SHALL on reset clear l2req_packet (all fields 0, valid=0), set last-grant pointer to NUM_REQUESTERS-1, and force req_ack=0 and pc_event_l2_stall=0 combinationally.
REQ-022 SHALL drop any in-flight packet on reset mid-transfer; requesters own the retry.

Configuration
REQ-023 SHALL with macro L2_ARB_ROUND_ROBIN_EN defined grant the first requesting index after the last-grant pointer, wrapping NUM_REQUESTERS-1 -> 0.
REQ-024 SHALL without L2_ARB_ROUND_ROBIN_EN grant the lowest requesting index (fixed priority); pointer still maintained but unused.

Structure
REQ-025 SHALL take l2req_packet_t and its op encodings from the shared defines package; NUM_REQUESTERS index constants belong there too.
REQ-026 SHALL place the grant logic in sub-module arbiter_rr (inputs request vector, update enable; output one-hot grant), instantiated once.

Verification
REQ-027 Single request: req_valid=3'b010, slot empty, l2req_ready=1 -> req_ack=3'b010 cycle N; l2req_packet.valid=1 with dcache packet cycle N+1.
REQ-028 Backpressure: packet held, l2req_ready=0 for 5 cycles -> packet unchanged, req_ack=0, pc_event_l2_stall=1 all 5 cycles.
REQ-029 Round-robin (macro on): req_valid=3'b111 held, l2req_ready=1 -> grants 0,1,2,0 on consecutive cycles, no bubbles.
REQ-030 Fixed priority (macro off): req_valid=3'b111 held -> grant 0 every cycle; requester 2 acked only after requesters 0 and 1 drop.
REQ-031 Back-to-back: accept and new grant same cycle -> new packet next cycle, valid never drops.
REQ-032 Reset mid-op: reset asserted with valid packet stalled -> l2req_packet.valid=0 immediately; after release, pending requester 0 granted first.
